// File: rtl/fetch_controller.sv
// fetch_controller
//   Fetch-stage sequencer for a 16-bit instruction memory. Owns the program
//   counter, drives the memory port, assembles one-word and two-word
//   (opcode + immediate) instructions into registered decode outputs, and
//   grants single-cycle program-loader writes on the shared memory port.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   stall                     decode cannot accept; freeze progress/outputs
//   redirect_en, redirect_pc  load PC, drop any half-assembled pair
//   load_req/addr/data        loader write request
//   load_ack                  write performed at this cycle's edge (comb)
//   mem_cs/read/write/addr    memory controls (comb)
//   mem_wdata, mem_rdata      memory data (rdata valid same cycle)
//   inst_valid, inst, imm, has_imm, inst_pc   registered decode outputs
module fetch_controller #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'd32,
  parameter logic [4:0]        IMM_OP   = 5'b00001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [15:0]       load_data,
  output logic              load_ack,
  output logic              mem_cs,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  output logic              inst_valid,
  output logic [15:0]       inst,
  output logic [15:0]       imm,
  output logic              has_imm,
  output logic [ADDR_W-1:0] inst_pc
);

  typedef enum logic [0:0] {FETCH = 1'b0, FETCH_IMM = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       hold_q, hold_d;
  logic [ADDR_W-1:0] hold_pc_q, hold_pc_d;
  logic              inst_valid_q, inst_valid_d;
  logic [15:0]       inst_q, inst_d;
  logic [15:0]       imm_q, imm_d;
  logic              has_imm_q, has_imm_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;

  // Loader data always goes straight to the memory; mem_write qualifies it.
  assign mem_wdata  = load_data;
  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign imm        = imm_q;
  assign has_imm    = has_imm_q;
  assign inst_pc    = inst_pc_q;

  // Next-state and memory-port control, in priority rst > redirect > load > fetch.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_d       = hold_q;
    hold_pc_d    = hold_pc_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    imm_d        = imm_q;
    has_imm_d    = has_imm_q;
    inst_pc_d    = inst_pc_q;
    mem_cs       = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr     = pc_q;
    load_ack     = 1'b0;

    if (rst) begin
      // Port stays idle; register reset values are applied in the flop block.
      state_d = FETCH;
    end else if (redirect_en) begin
      // Redirect overrides stall; a half-assembled pair is simply abandoned.
      pc_d         = redirect_pc;
      state_d      = FETCH;
      inst_valid_d = 1'b0;
      has_imm_d    = 1'b0;
    end else if ((state_q == FETCH) && load_req) begin
      // Loader owns the port this cycle; in FETCH_IMM it must wait for the pair.
      mem_cs    = 1'b1;
      mem_write = 1'b1;
      mem_addr  = load_addr;
      load_ack  = 1'b1;
      if (!stall) begin
        inst_valid_d = 1'b0;
      end else begin
        inst_valid_d = inst_valid_q;
      end
    end else begin
      mem_cs   = 1'b1;
      mem_read = 1'b1;
      if (!stall) begin
        pc_d = pc_q + PC_ONE;
        case (state_q)
          FETCH: begin
            if (mem_rdata[15:11] == IMM_OP) begin
              hold_d       = mem_rdata;
              hold_pc_d    = pc_q;
              state_d      = FETCH_IMM;
              inst_valid_d = 1'b0;
            end else begin
              inst_d       = mem_rdata;
              inst_pc_d    = pc_q;
              imm_d        = 16'h0000;
              has_imm_d    = 1'b0;
              inst_valid_d = 1'b1;
            end
          end
          FETCH_IMM: begin
            inst_d       = hold_q;
            imm_d        = mem_rdata;
            inst_pc_d    = hold_pc_q;
            has_imm_d    = 1'b1;
            inst_valid_d = 1'b1;
            state_d      = FETCH;
          end
          default: begin
            state_d = FETCH;
          end
        endcase
      end else begin
        pc_d = pc_q;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      hold_q       <= 16'h0000;
      hold_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      inst_q       <= 16'h0000;
      imm_q        <= 16'h0000;
      has_imm_q    <= 1'b0;
      inst_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_q       <= hold_d;
      hold_pc_q    <= hold_pc_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      imm_q        <= imm_d;
      has_imm_q    <= has_imm_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

endmodule
